sn74ls161_updown_counter: RTL and testbench
===========================================

Name: sn74ls161_updown_counter

Overview:
- Synchronous up/down binary counter with parallel load and synchronous clear, modelled on the 74LS161/191 family.
- Sits directly upstream of the triple 3-input AND stage. Its Q bits and ripple-carry output feed 3-input AND gates for terminal-count decoding and for cascading multiple counters.
- Cascading follows the 74-series convention: RCO of stage n drives ENT of stage n+1, and all stages share one clock.

Parameters:
WIDTH, 4, counter width in bits (legal range 2..16)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_CLR  input  1  synchronous clear, active-high
in_LOAD  input  1  synchronous parallel load, active-high
in_ENP  input  1  count enable P, active-high (does not gate RCO)
in_ENT  input  1  count enable T, active-high (also gates RCO)
in_DOWN  input  1  direction: 0 = count up, 1 = count down
in_D  input  WIDTH  parallel load data
out_Q  output  WIDTH  registered count value
out_RCO  output  1  ripple carry/borrow out, combinational
out_MAXMIN  output  1  terminal-count flag, combinational, not gated by ENT

Behaviour:
- Single clock domain. The only state is out_Q; every update happens on the rising edge of clk, except reset.
- Reset: rst=1 forces out_Q=0 immediately, with no clock needed, and holds it while rst stays high.
  - Derived outputs during reset: out_MAXMIN = in_DOWN; out_RCO = in_ENT & in_DOWN.
  - Deasserting rst: the first rising edge after rst falls is a normal functional edge.
  - rst asserted mid-count: Q goes to 0 asynchronously; the count in progress is discarded.
- Edge priority, highest first, evaluated at each rising clk when rst=0:
  1. in_CLR=1: Q <= 0.
  2. in_LOAD=1: Q <= in_D.
  3. in_ENP=1 and in_ENT=1: Q <= Q+1 when in_DOWN=0, Q <= Q-1 when in_DOWN=1.
  4. Otherwise Q holds.
- Clear and load ignore ENP, ENT and DOWN. CLR and LOAD asserted together: clear wins.
- Arithmetic is modulo 2^WIDTH.
  - Up-count wraps from 2^WIDTH-1 to 0.
  - Down-count wraps from 0 to 2^WIDTH-1.
  - No saturation; no other illegal states exist.
- Terminal count:
  - TC = (in_DOWN=0 and Q = all ones) or (in_DOWN=1 and Q = 0).
  - out_MAXMIN = TC.
  - out_RCO = TC & in_ENT.
  - Both are purely combinational from Q, DOWN and ENT, with zero-cycle latency.
  - A DOWN change mid-cycle updates TC within the same cycle.
- Latency: load, clear and count take effect on the next edge; out_Q changes only after an edge or an async reset.
- Cascading: stage n+1 must see its ENT = RCO of stage n. Stage n+1 then increments exactly on the edge where stage n wraps.
- Direction change while counting: takes effect on the next edge, with no extra cycle of delay.
- No X propagation allowed on outputs once rst has been applied once.

Test Plan:
- Reset: assert rst mid-count with Q=0x9, no clock edge -> out_Q=0x0 immediately. With DOWN=0, ENT=1 -> RCO=0, MAXMIN=0. Set DOWN=1 -> RCO=1, MAXMIN=1.
- Up-count wrap, WIDTH=4: LOAD D=0xE, then ENP=ENT=1, DOWN=0 for 3 edges -> Q = 0xF, 0x0, 0x1. RCO=1 only while Q=0xF. Repeat with ENT=0 at Q=0xF -> RCO=0, MAXMIN=1, Q holds.
- Down-count wrap: LOAD D=0x1, DOWN=1, ENP=ENT=1 for 3 edges -> Q = 0x0, 0xF, 0xE. RCO=1 only at Q=0x0.
- Priority: same edge with CLR=1, LOAD=1, D=0xA, ENP=ENT=1 -> Q=0x0. Next edge with CLR=0, LOAD=1 -> Q=0xA. Then ENP=0, ENT=1 -> Q holds 0xA.
- Cascade: two 4-bit instances, stage0 RCO to stage1 ENT, both ENP=1, up-count from 0x00 for 256 edges -> combined {Q1,Q0} increments by one each edge and wraps 0xFF to 0x00. Stage1 RCO=1 only at 0xFF.
- Direction flip: count up to Q=0x5, set DOWN=1 between edges -> next edge gives Q=0x4 and MAXMIN tracks DOWN combinationally.

Source files
------------

// File: rtl/sn74ls161_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sn74ls161_updown_counter                                         |
// | Brief   : Synchronous up/down binary counter with parallel load, sync      |
// |           clear, async reset and cascadable ripple-carry/borrow output.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sn74ls161_updown_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_CLR,
   input  logic             in_LOAD,
   input  logic             in_ENP,
   input  logic             in_ENT,
   input  logic             in_DOWN,
   input  logic [WIDTH-1:0] in_D,
   output logic [WIDTH-1:0] out_Q,
   output logic             out_RCO,
   output logic             out_MAXMIN
);

   localparam logic [WIDTH-1:0] c_zero = '0;
   localparam logic [WIDTH-1:0] c_ones = '1;
   localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_step;
   logic             w_tc;

   // Modulo-2^WIDTH step; wrap in both directions falls out of the width.
   assign w_q_step = in_DOWN ? (r_q - c_one) : (r_q + c_one);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= c_zero;
      end else if (in_CLR) begin
         r_q <= c_zero;
      end else if (in_LOAD) begin
         r_q <= in_D;
      end else if (in_ENP && in_ENT) begin
         r_q <= w_q_step;
      end
   end

   // Terminal count follows DOWN combinationally so a direction flip is seen
   // by a downstream stage within the same cycle.
   assign w_tc = in_DOWN ? (r_q == c_zero) : (r_q == c_ones);

   assign out_Q      = r_q;
   assign out_MAXMIN = w_tc;
   assign out_RCO    = w_tc & in_ENT;

endmodule
`default_nettype wire

// File: tb/tb_sn74ls161_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sn74ls161_updown_counter                                      |
// | Brief   : Scoreboard bench for a single 4-bit counter and a 2-stage chain. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sn74ls161_updown_counter;

   typedef struct {
      string       tag;
      bit          casc;
      logic [15:0] q;
      logic        rco;
      logic        mm;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr, load, enp, ent, down;
   logic [3:0] d;
   logic [3:0] q;
   logic       rco, mm;

   logic       c_load, c_enp;
   logic [3:0] c_q0, c_q1;
   logic       c_rco0, c_rco1, c_mm0, c_mm1;

   always #5 clk = ~clk;

   sn74ls161_updown_counter #(.WIDTH(4)) u_dut (
      .clk(clk), .rst(rst), .in_CLR(clr), .in_LOAD(load), .in_ENP(enp),
      .in_ENT(ent), .in_DOWN(down), .in_D(d),
      .out_Q(q), .out_RCO(rco), .out_MAXMIN(mm)
   );

   sn74ls161_updown_counter #(.WIDTH(4)) u_stage0 (
      .clk(clk), .rst(rst), .in_CLR(1'b0), .in_LOAD(c_load), .in_ENP(c_enp),
      .in_ENT(1'b1), .in_DOWN(1'b0), .in_D(4'h0),
      .out_Q(c_q0), .out_RCO(c_rco0), .out_MAXMIN(c_mm0)
   );

   sn74ls161_updown_counter #(.WIDTH(4)) u_stage1 (
      .clk(clk), .rst(rst), .in_CLR(1'b0), .in_LOAD(c_load), .in_ENP(c_enp),
      .in_ENT(c_rco0), .in_DOWN(1'b0), .in_D(4'h0),
      .out_Q(c_q1), .out_RCO(c_rco1), .out_MAXMIN(c_mm1)
   );

   task automatic check_value(input string tag, input logic [15:0] obs,
                              input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pops the oldest expectation and compares it with whichever DUT it names.
   task automatic sample();
      exp_t e;
      if (sb.size() == 0) begin
         check_value("sb_empty", 16'd1, 16'd0);
         return;
      end
      e = sb.pop_front();
      if (e.casc) begin
         check_value({e.tag, "_q"},   {8'h00, c_q1, c_q0}, e.q);
         check_value({e.tag, "_rco"}, {15'h0, c_rco1},     {15'h0, e.rco});
      end else begin
         check_value({e.tag, "_q"},   {12'h000, q},  e.q);
         check_value({e.tag, "_rco"}, {15'h0, rco},  {15'h0, e.rco});
         check_value({e.tag, "_mm"},  {15'h0, mm},   {15'h0, e.mm});
      end
   endtask

   task automatic step(input string tag, input logic [15:0] eq,
                       input logic erco, input logic emm);
      sb.push_back('{tag, 1'b0, eq, erco, emm});
      @(posedge clk);
      #1;
      sample();
   endtask

   task automatic cstep(input string tag, input logic [15:0] eq, input logic erco);
      sb.push_back('{tag, 1'b1, eq, erco, 1'b0});
      @(posedge clk);
      #1;
      sample();
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; load = 1'b0; enp = 1'b0; ent = 1'b0; down = 1'b0;
      d = 4'h0; c_load = 1'b0; c_enp = 1'b0;

      #12;
      check_value("rst_q",  {12'h0, q},  16'h0);
      check_value("rst_mm", {15'h0, mm}, 16'h0);
      down = 1'b1; #1;
      check_value("rst_dn_mm",  {15'h0, mm},  16'h1);
      check_value("rst_dn_rco", {15'h0, rco}, 16'h0);
      down = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;

      // Async reset in the middle of a count
      load = 1'b1; d = 4'h9;
      step("ld9", 16'h9, 1'b0, 1'b0);
      load = 1'b0; enp = 1'b1; ent = 1'b1;
      #2 rst = 1'b1; #1;
      check_value("arst_q",   {12'h0, q},   16'h0);
      check_value("arst_rco", {15'h0, rco}, 16'h0);
      check_value("arst_mm",  {15'h0, mm},  16'h0);
      down = 1'b1; #1;
      check_value("arst_dn_rco", {15'h0, rco}, 16'h1);
      check_value("arst_dn_mm",  {15'h0, mm},  16'h1);
      rst = 1'b0; down = 1'b0; enp = 1'b0;
      step("hold0", 16'h0, 1'b0, 1'b0);

      // Up wrap
      load = 1'b1; d = 4'hE;
      step("ldE", 16'hE, 1'b0, 1'b0);
      load = 1'b0; enp = 1'b1; ent = 1'b1;
      step("upF", 16'hF, 1'b1, 1'b1);
      step("up0", 16'h0, 1'b0, 1'b0);
      step("up1", 16'h1, 1'b0, 1'b0);

      // ENT low at terminal count blocks RCO and counting, not MAXMIN
      load = 1'b1; d = 4'hE;
      step("ldE2", 16'hE, 1'b0, 1'b0);
      load = 1'b0;
      step("upF2", 16'hF, 1'b1, 1'b1);
      ent = 1'b0; #1;
      check_value("entlo_rco", {15'h0, rco}, 16'h0);
      check_value("entlo_mm",  {15'h0, mm},  16'h1);
      step("entlo_hold", 16'hF, 1'b0, 1'b1);

      // Down wrap
      load = 1'b1; d = 4'h1; down = 1'b1; enp = 1'b0; ent = 1'b1;
      step("ld1", 16'h1, 1'b0, 1'b0);
      load = 1'b0; enp = 1'b1;
      step("dn0", 16'h0, 1'b1, 1'b1);
      step("dnF", 16'hF, 1'b0, 1'b0);
      step("dnE", 16'hE, 1'b0, 1'b0);

      // Priority: clear over load over count
      down = 1'b0; clr = 1'b1; load = 1'b1; d = 4'hA;
      step("clr_wins", 16'h0, 1'b0, 1'b0);
      clr = 1'b0;
      step("ldA", 16'hA, 1'b0, 1'b0);
      load = 1'b0; enp = 1'b0;
      step("enp_lo", 16'hA, 1'b0, 1'b0);
      step("enp_lo2", 16'hA, 1'b0, 1'b0);

      // Direction flip between edges
      load = 1'b1; d = 4'h3;
      step("ld3", 16'h3, 1'b0, 1'b0);
      load = 1'b0; enp = 1'b1;
      step("up4", 16'h4, 1'b0, 1'b0);
      step("up5", 16'h5, 1'b0, 1'b0);
      down = 1'b1; #1;
      check_value("flip_mm", {15'h0, mm}, 16'h0);
      step("flip4", 16'h4, 1'b0, 1'b0);
      step("flip3", 16'h3, 1'b0, 1'b0);
      enp = 1'b0;

      // Two-stage cascade through RCO -> ENT
      c_load = 1'b1;
      cstep("c_ld", 16'h00, 1'b0);
      c_load = 1'b0; c_enp = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         cstep("casc", 16'(i % 256), ((i % 256) == 255) ? 1'b1 : 1'b0);
      end
      c_enp = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
